// File: rtl/id_token_stats.sv
// Token statistics for the identifier recognizer: converts each run of match=1
// (trailing digits of an identifier) into a length/value record and keeps totals.
module id_token_stats #(
    parameter int CNT_W = 8,
    parameter int LEN_W = 4,
    parameter int NUM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       char,
    input  logic             match,
    input  logic             clear,
    output logic             token_done,
    output logic [LEN_W-1:0] token_len,
    output logic [NUM_W-1:0] token_num,
    output logic             token_ovf,
    output logic [CNT_W-1:0] token_cnt,
    output logic [LEN_W-1:0] max_len
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SKIP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [NUM_W-1:0] NUM_MAX = '1;

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       char_d;
    logic [LEN_W-1:0] run_len;
    logic [NUM_W-1:0] acc;
    logic             ovf_acc;

    logic [NUM_W+3:0] acc_wide;
    logic [NUM_W+3:0] acc_next;
    logic             acc_sat;
    logic             start_run;
    logic             step_run;
    logic             end_run;
    logic             unused_hi;

    // match qualifies the character registered on the previous edge
    assign acc_wide  = (NUM_W + 4)'(acc);
    assign acc_next  = acc_wide * (NUM_W + 4)'(10) + (NUM_W + 4)'(char_d[3:0]);
    assign acc_sat   = acc_next > (NUM_W + 4)'(NUM_MAX);
    assign start_run = (state_q == IDLE) && match;
    assign step_run  = (state_q == RUN) && match;
    assign end_run   = (state_q == RUN) && !match;
    assign unused_hi = ^char_d[7:4];

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = match ? SKIP : IDLE;
        end else begin
            case (state_q)
                IDLE:    if (match)  state_d = RUN;
                RUN:     if (!match) state_d = IDLE;
                SKIP:    if (!match) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            char_d  <= '0;
        end else begin
            state_q <= state_d;
            char_d  <= char;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_len    <= '0;
            acc        <= '0;
            ovf_acc    <= 1'b0;
            token_done <= 1'b0;
            token_len  <= '0;
            token_num  <= '0;
            token_ovf  <= 1'b0;
            token_cnt  <= '0;
            max_len    <= '0;
        end else if (clear) begin
            run_len    <= '0;
            acc        <= '0;
            ovf_acc    <= 1'b0;
            token_done <= 1'b0;
            token_len  <= '0;
            token_num  <= '0;
            token_ovf  <= 1'b0;
            token_cnt  <= '0;
            max_len    <= '0;
        end else begin
            token_done <= 1'b0;
            if (start_run) begin
                run_len <= LEN_W'(1);
                acc     <= NUM_W'(char_d[3:0]);
                ovf_acc <= 1'b0;
            end else if (step_run) begin
                if (run_len != LEN_MAX) run_len <= run_len + 1'b1;
                if (acc_sat) begin
                    acc     <= NUM_MAX;
                    ovf_acc <= 1'b1;
                end else begin
                    acc <= acc_next[NUM_W-1:0];
                end
            end else if (end_run) begin
                token_done <= 1'b1;
                token_len  <= run_len;
                token_num  <= acc;
                token_ovf  <= ovf_acc;
                if (token_cnt != CNT_MAX) token_cnt <= token_cnt + 1'b1;
                if (run_len > max_len) max_len <= run_len;
            end
        end
    end

endmodule

// File: tb/tb_id_token_stats.sv
// Directed bench for id_token_stats: a behavioural token model pushes expected
// records into a queue that is popped whenever the DUT pulses token_done.
module tb_id_token_stats;

    localparam int CNT_W = 8;
    localparam int LEN_W = 4;
    localparam int NUM_W = 16;
    localparam int REC_W = LEN_W + NUM_W + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       char_i = 8'd0;
    logic             match = 1'b0;
    logic             clear = 1'b0;
    logic             token_done;
    logic [LEN_W-1:0] token_len;
    logic [NUM_W-1:0] token_num;
    logic             token_ovf;
    logic [CNT_W-1:0] token_cnt;
    logic [LEN_W-1:0] max_len;

    logic [REC_W-1:0] exp_q[$];
    int n_assert = 0;
    int n_fail = 0;

    int  m_len, m_val;
    bit  m_run, m_skip;
    byte prev_char;
    int  e_cnt, e_max, e_len, e_num, e_ovf;
    bit  e_pulse;
    bit  id_in, id_flag;

    id_token_stats #(.CNT_W(CNT_W), .LEN_W(LEN_W), .NUM_W(NUM_W)) dut (
        .clk(clk), .rst_n(rst_n), .char(char_i), .match(match), .clear(clear),
        .token_done(token_done), .token_len(token_len), .token_num(token_num),
        .token_ovf(token_ovf), .token_cnt(token_cnt), .max_len(max_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_skip = 0; m_len = 0; m_val = 0; prev_char = 0;
        e_cnt = 0; e_max = 0; e_len = 0; e_num = 0; e_ovf = 0; e_pulse = 0;
        id_in = 0; id_flag = 0;
        exp_q.delete();
    endtask

    // Reference behaviour with unbounded arithmetic, saturated only when a record is formed
    task automatic model_step(input logic m, input logic clr);
        int d;
        d = int'(prev_char[3:0]);
        e_pulse = 0;
        if (clr) begin
            m_run = 0; m_skip = m;
            e_cnt = 0; e_max = 0; e_len = 0; e_num = 0; e_ovf = 0;
        end else if (m_skip) begin
            if (!m) m_skip = 0;
        end else if (m_run) begin
            if (m) begin
                m_len++;
                m_val = m_val * 10 + d;
                if (m_val > 1000000) m_val = 1000000;
            end else begin
                m_run = 0;
                e_pulse = 1;
                e_len = (m_len > 15) ? 15 : m_len;
                e_ovf = (m_val > 65535) ? 1 : 0;
                e_num = e_ovf ? 65535 : m_val;
                if (e_cnt < 255) e_cnt++;
                if (e_len > e_max) e_max = e_len;
                exp_q.push_back({LEN_W'(e_len), NUM_W'(e_num), 1'(e_ovf)});
            end
        end else if (m) begin
            m_run = 1; m_len = 1; m_val = d;
        end
    endtask

    task automatic check_outputs();
        logic [REC_W-1:0] rec;
        check("token_done", 32'(token_done), 32'(e_pulse));
        if (token_done === 1'b1) begin
            check("record_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                rec = exp_q.pop_front();
                check("record", 32'({token_len, token_num, token_ovf}), 32'(rec));
            end
        end
        check("token_len", 32'(token_len), 32'(e_len));
        check("token_num", 32'(token_num), 32'(e_num));
        check("token_ovf", 32'(token_ovf), 32'(e_ovf));
        check("token_cnt", 32'(token_cnt), 32'(e_cnt));
        check("max_len", 32'(max_len), 32'(e_max));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, 32'(token_done), 32'd0);
        check({tag, "_len"}, 32'(token_len), 32'd0);
        check({tag, "_num"}, 32'(token_num), 32'd0);
        check({tag, "_ovf"}, 32'(token_ovf), 32'd0);
        check({tag, "_cnt"}, 32'(token_cnt), 32'd0);
        check({tag, "_max"}, 32'(max_len), 32'd0);
    endtask

    task automatic drive(input byte c, input logic m, input logic clr);
        char_i = c; match = m; clear = clr;
        model_step(m, clr);
        prev_char = c;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Stand-in for the recognizer: registered out is 1 for a digit inside an identifier
    task automatic stream(input string s);
        bit f;
        for (int i = 0; i < s.len(); i++) begin
            drive(s[i], id_flag, 1'b0);
            if ((s[i] >= "a" && s[i] <= "z") || (s[i] >= "A" && s[i] <= "Z")) begin
                id_in = 1; f = 0;
            end else if (s[i] >= "0" && s[i] <= "9") begin
                f = id_in;
            end else begin
                id_in = 0; f = 0;
            end
            id_flag = f;
        end
        drive(" ", id_flag, 1'b0);
        id_flag = 0;
        drive(" ", 1'b0, 1'b0);
        drive(" ", 1'b0, 1'b0);
    endtask

    // Directly drives match for each digit, qualifying it one cycle later
    task automatic run_digits(input string s);
        drive(s[0], 1'b0, 1'b0);
        for (int i = 1; i < s.len(); i++) drive(s[i], 1'b1, 1'b0);
        drive(" ", 1'b1, 1'b0);
        drive(" ", 1'b0, 1'b0);
        drive(" ", 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        stream("ab12 ");
        check("ab12_cnt", 32'(token_cnt), 32'd1);
        check("ab12_num", 32'(token_num), 32'd12);

        stream("x7 y3456 z9 ");
        check("multi_cnt", 32'(token_cnt), 32'd4);
        check("multi_max", 32'(max_len), 32'd4);
        check("multi_hold_num", 32'(token_num), 32'd9);

        run_digits("99999999999999999999");
        check("sat_len", 32'(token_len), 32'd15);
        check("sat_num", 32'(token_num), 32'd65535);
        check("sat_ovf", 32'(token_ovf), 32'd1);
        run_digits("42");
        check("after_sat_num", 32'(token_num), 32'd42);
        check("after_sat_ovf", 32'(token_ovf), 32'd0);

        // Clear in the middle of a three-cycle run
        drive("1", 1'b0, 1'b0);
        drive("2", 1'b1, 1'b0);
        drive("3", 1'b1, 1'b1);
        drive(" ", 1'b1, 1'b0);
        drive(" ", 1'b0, 1'b0);
        drive(" ", 1'b0, 1'b0);
        check("clr_mid_cnt", 32'(token_cnt), 32'd0);
        run_digits("5");
        check("post_clr_cnt", 32'(token_cnt), 32'd1);
        check("post_clr_num", 32'(token_num), 32'd5);

        // Clear on the end-of-run edge drops the record
        drive("7", 1'b0, 1'b0);
        drive(" ", 1'b1, 1'b0);
        drive(" ", 1'b0, 1'b1);
        check_all_zero("clr_end");
        drive(" ", 1'b0, 1'b0);

        // Asynchronous reset in the middle of a run
        run_digits("63");
        drive("8", 1'b0, 1'b0);
        drive("8", 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        match = 1'b0; char_i = 8'd0; clear = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        drive(" ", 1'b0, 1'b0);

        // Back-to-back single-digit tokens past the counter limit
        for (int i = 0; i < 260; i++) begin
            drive("5", 1'b0, 1'b0);
            drive(" ", 1'b1, 1'b0);
        end
        drive(" ", 1'b0, 1'b0);
        drive(" ", 1'b0, 1'b0);
        check("cnt_saturated", 32'(token_cnt), 32'd255);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
